// File: rtl/solver_cpu_debug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : solver_cpu_debug_pkg                                             |
// | Purpose : Shared types and default widths for the system-clock half of    |
// |           the debug slave (strobe sync, command FIFO, dispatcher).         |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package solver_cpu_debug_pkg;

  localparam int c_SR_W = 38;
  localparam int c_IR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } dispatch_state_e;

  // Command as captured at default widths, for consumers that pass whole
  // commands around rather than the split jdo/channel form.
  typedef struct packed {
    logic [c_IR_W-1:0] ir;
    logic [c_SR_W-1:0] dr;
  } debug_cmd_t;

endpackage
`default_nettype wire

// File: rtl/solver_cpu_debug_strobe_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : solver_cpu_debug_strobe_sync                                     |
// | Purpose : Brings one TCK-domain level strobe into clk through a flop chain |
// |           and produces a single-cycle rise indication.                     |
// | Ports   : clk, reset (async, active high), strobe_i (async level),         |
// |           rise_o (1 clk high on each synchronised rising edge)             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module solver_cpu_debug_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule
`default_nettype wire

// File: rtl/solver_cpu_debug_cmd_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : solver_cpu_debug_cmd_dispatch                                    |
// | Purpose : Synchronises update-IR / exit1-DR strobes, queues captured DR    |
// |           words with their IR, and dispatches them one at a time as        |
// |           one-hot take_action / take_no_action pulses with a per-channel   |
// |           ready handshake and sticky overflow reporting.                   |
// | Ports   : clk, reset (async, active high)                                  |
// |           sr_i, ir_i, uir_i, e1dr_i   : TCK-domain capture inputs          |
// |           cmd_ready_i, clear_ovf_i    : consumer handshake / ovf clear     |
// |           jdo_o, take_action_o, take_no_action_o : issued command          |
// |           busy_o, fifo_level_o, overflow_o       : status                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module solver_cpu_debug_cmd_dispatch
  import solver_cpu_debug_pkg::*;
#(
  parameter int SR_W        = c_SR_W,
  parameter int IR_W        = c_IR_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACT_BIT     = 35
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SR_W-1:0]               sr_i,
  input  logic [IR_W-1:0]               ir_i,
  input  logic                          uir_i,
  input  logic                          e1dr_i,
  input  logic [(2**IR_W)-1:0]          cmd_ready_i,
  input  logic                          clear_ovf_i,
  output logic [SR_W-1:0]               jdo_o,
  output logic [(2**IR_W)-1:0]          take_action_o,
  output logic [(2**IR_W)-1:0]          take_no_action_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int NUM_CH   = 2**IR_W;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  localparam int ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam int ARM_LOAD = SYNC_STAGES + 1;

  // Strobe synchronisers
  logic w_uir_raw, w_e1dr_raw;

  solver_cpu_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (uir_i),
    .rise_o   (w_uir_raw)
  );

  solver_cpu_debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_e1dr_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_i (e1dr_i),
    .rise_o   (w_e1dr_raw)
  );

  // A strobe already high when reset releases would otherwise look like a
  // fresh rise once it reaches the end of the chain; hold off until the
  // chain has flushed.
  logic [ARM_W-1:0] arm_q;
  logic             w_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              arm_q <= ARM_W'(ARM_LOAD);
    else if (arm_q != '0)   arm_q <= arm_q - ARM_W'(1);
  end

  assign w_armed = (arm_q == '0);

  logic w_uir_rise, w_e1dr_rise;
  assign w_uir_rise  = w_uir_raw  & w_armed;
  assign w_e1dr_rise = w_e1dr_raw & w_armed;

  // Command FIFO
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] fifo_ir_q [FIFO_DEPTH];
  logic [SR_W-1:0] fifo_dr_q [FIFO_DEPTH];
  logic [LW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   w_level;
  logic            w_empty, w_full, w_pop, w_push, w_drop;
  logic [IR_W-1:0] w_push_ir;

  assign w_level = wr_ptr_q - rd_ptr_q;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == LW'(FIFO_DEPTH));
  // A pop in the same clock frees a slot, so a full FIFO still accepts.
  assign w_push  = w_e1dr_rise & (~w_full | w_pop);
  assign w_drop  = w_e1dr_rise & w_full & ~w_pop;
  // Coincident update-IR belongs to this capture, so bypass ir_q.
  assign w_push_ir = w_uir_rise ? ir_i : ir_q;

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_ir_q[wr_ptr_q[AW-1:0]] <= w_push_ir;
      fifo_dr_q[wr_ptr_q[AW-1:0]] <= sr_i;
    end
  end

  // Dispatcher
  dispatch_state_e state_q, state_d;
  logic [SR_W-1:0] jdo_q, jdo_d;
  logic [IR_W-1:0] ch_q, ch_d;
  logic            ovf_q;

  always_comb begin
    state_d          = state_q;
    jdo_d            = jdo_q;
    ch_d             = ch_q;
    w_pop            = 1'b0;
    take_action_o    = '0;
    take_no_action_o = '0;
    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          jdo_d   = fifo_dr_q[rd_ptr_q[AW-1:0]];
          ch_d    = fifo_ir_q[rd_ptr_q[AW-1:0]];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (jdo_q[ACT_BIT]) take_action_o[ch_q]    = 1'b1;
        else                take_no_action_o[ch_q] = 1'b1;
        // Ready seen during the pulse cycle belongs to the previous
        // command's handshake, so it is never looked at here.
        state_d = WAIT;
      end
      WAIT: begin
        if (cmd_ready_i[ch_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      jdo_q    <= '0;
      ch_q     <= '0;
      ir_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      jdo_q   <= jdo_d;
      ch_q    <= ch_d;
      if (w_uir_rise) ir_q <= ir_i;
      if (w_push)     wr_ptr_q <= wr_ptr_q + LW'(1);
      if (w_pop)      rd_ptr_q <= rd_ptr_q + LW'(1);
      if (w_drop)           ovf_q <= 1'b1;
      else if (clear_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign jdo_o        = jdo_q;
  assign busy_o       = (state_q != IDLE);
  assign fifo_level_o = w_level;
  assign overflow_o   = ovf_q;

  logic w_unused_ch;
  assign w_unused_ch = (NUM_CH == 0);

endmodule
`default_nettype wire
